// File: rtl/segre_mem_arbiter.sv
// rtl/segre_mem_arbiter.sv - shares one memory port between instruction fetch and data memops
module segre_mem_arbiter #(
  parameter int WORD_SIZE     = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_req_i,
  input  logic [WORD_SIZE-1:0] if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rvalid_o,
  output logic [WORD_SIZE-1:0] if_rdata_o,
  input  logic                 dm_req_i,
  input  logic                 dm_we_i,
  input  logic [WORD_SIZE-1:0] dm_addr_i,
  input  logic [WORD_SIZE-1:0] dm_wdata_i,
  input  logic [1:0]           dm_type_i,
  input  logic                 dm_sign_ext_i,
  output logic                 dm_gnt_o,
  output logic                 dm_rvalid_o,
  output logic [WORD_SIZE-1:0] dm_rdata_o,
  output logic                 dm_misaligned_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  output logic [3:0]           mem_be_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  input  logic                 mem_ready_i,
  input  logic                 mem_rvalid_i,
  input  logic [WORD_SIZE-1:0] mem_rdata_i
);

  // memop_data_type_e encoding
  localparam logic [1:0] TYPE_BYTE = 2'd0;
  localparam logic [1:0] TYPE_HALF = 2'd1;
  localparam logic [1:0] TYPE_WORD = 2'd2;

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        streak_q;
  logic                 owner_dm_q, we_q, sign_ext_q;
  logic [1:0]           type_q;
  logic [WORD_SIZE-1:0] addr_q, wdata_q;
  logic [3:0]           be_q;
  logic [WORD_SIZE-1:0] if_rdata_q, dm_rdata_q;

  logic                 pick_dm, pick_if, dm_misaligned, dm_accept;
  logic [3:0]           st_be;
  logic [WORD_SIZE-1:0] st_wdata, ld_shift, ld_data;

  assign dm_misaligned = (dm_type_i == TYPE_HALF && dm_addr_i[0]) ||
                         (dm_type_i == TYPE_WORD && dm_addr_i[1:0] != 2'b00);
  assign dm_accept     = pick_dm && !dm_misaligned;

  // Arbitration in IDLE: DM wins until its streak saturates while IF is waiting
  always_comb begin
    pick_dm = 1'b0;
    pick_if = 1'b0;
    if (state_q == IDLE && !rst_i) begin
      pick_dm = dm_req_i && (!if_req_i || streak_q < STREAK_MAX);
      pick_if = if_req_i && !pick_dm;
    end
  end

  // Store lane alignment; loads use all lanes and carry no write data
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = dm_wdata_i;
    case (dm_type_i)
      TYPE_BYTE: begin
        st_be    = 4'b0001 << dm_addr_i[1:0];
        st_wdata = {4{dm_wdata_i[7:0]}};
      end
      TYPE_HALF: begin
        st_be    = 4'b0011 << dm_addr_i[1:0];
        st_wdata = {2{dm_wdata_i[15:0]}};
      end
      default: ;
    endcase
    if (!dm_we_i) begin
      st_be    = 4'b1111;
      st_wdata = '0;
    end
  end

  // Load alignment and extension from the latched request fields
  always_comb begin
    ld_shift = mem_rdata_i >> {addr_q[1:0], 3'b000};
    case (type_q)
      TYPE_BYTE: ld_data = {{(WORD_SIZE-8){sign_ext_q & ld_shift[7]}}, ld_shift[7:0]};
      TYPE_HALF: ld_data = {{(WORD_SIZE-16){sign_ext_q & ld_shift[15]}}, ld_shift[15:0]};
      default:   ld_data = mem_rdata_i;
    endcase
    if (we_q) ld_data = '0;
  end

  // Capture the winning request so the memory side sees stable fields
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      type_q     <= TYPE_BYTE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else if (pick_if) begin
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      type_q     <= TYPE_WORD;
      addr_q     <= if_addr_i;
      be_q       <= 4'b1111;
      wdata_q    <= '0;
    end else if (dm_accept) begin
      owner_dm_q <= 1'b1;
      we_q       <= dm_we_i;
      sign_ext_q <= dm_sign_ext_i;
      type_q     <= dm_type_i;
      addr_q     <= dm_addr_i;
      be_q       <= st_be;
      wdata_q    <= st_wdata;
    end
  end

  // Count DM grants taken while IF waits; misaligned rejects leave it alone
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else if (state_q == IDLE) begin
      if (!if_req_i || pick_if)
        streak_q <= '0;
      else if (dm_accept && streak_q != STREAK_MAX)
        streak_q <= streak_q + SW'(1);
    end
  end

  // Keep the last delivered read data visible between responses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (state_q == RESP && mem_rvalid_i) begin
      if (owner_dm_q) dm_rdata_q <= ld_data;
      else            if_rdata_q <= mem_rdata_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: one transaction in flight, responses only accepted in RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_if || dm_accept) state_d = REQ;
      REQ:     if (mem_ready_i)          state_d = RESP;
      RESP:    if (mem_rvalid_i)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grants in IDLE, memory request in REQ, response routing in RESP
  always_comb begin
    if_gnt_o        = pick_if;
    dm_gnt_o        = pick_dm;
    dm_misaligned_o = pick_dm && dm_misaligned;
    if_rvalid_o     = 1'b0;
    dm_rvalid_o     = 1'b0;
    if_rdata_o      = if_rdata_q;
    dm_rdata_o      = dm_rdata_q;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_be_o        = '0;
    mem_wdata_o     = '0;
    case (state_q)
      REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = {addr_q[WORD_SIZE-1:2], 2'b00};
        mem_be_o    = be_q;
        mem_wdata_o = wdata_q;
      end
      RESP: begin
        if (mem_rvalid_i) begin
          if (owner_dm_q) begin
            dm_rvalid_o = 1'b1;
            dm_rdata_o  = ld_data;
          end else begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb/tb_segre_mem_arbiter.sv - directed self-checking bench for segre_mem_arbiter
module tb_segre_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i, dm_we_i, dm_sign_ext_i;
  logic [31:0] dm_addr_i, dm_wdata_i;
  logic [1:0]  dm_type_i;
  logic        dm_gnt_o, dm_rvalid_o, dm_misaligned_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  typ;
    logic        sext;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  segre_mem_arbiter #(.WORD_SIZE(32), .MAX_DM_STREAK(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_type_i(dm_type_i), .dm_sign_ext_i(dm_sign_ext_i),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .dm_misaligned_o(dm_misaligned_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic quiet_inputs();
    if_req_i = 0; if_addr_i = 0;
    dm_req_i = 0; dm_we_i = 0; dm_addr_i = 0; dm_wdata_i = 0; dm_type_i = 0; dm_sign_ext_i = 0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1;
    quiet_inputs();
    @(negedge clk_i); #1;
    total++;
    if ({if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, dm_misaligned_o, mem_req_o, mem_we_o} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0", {if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, dm_misaligned_o, mem_req_o, mem_we_o});
    end
    total++;
    if ({mem_addr_o, mem_be_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== '0) begin
      bad++; $display("FAIL reset_buses: addr=%h be=%h wdata=%h if_rdata=%h dm_rdata=%h want all 0", mem_addr_o, mem_be_o, mem_wdata_o, if_rdata_o, dm_rdata_o);
    end
    if_req_i = 1; dm_req_i = 1; #1;
    total++;
    if ({if_gnt_o, dm_gnt_o} !== 2'b00) begin
      bad++; $display("FAIL reset_no_grant: got %b want 00", {if_gnt_o, dm_gnt_o});
    end
    @(negedge clk_i);
    quiet_inputs();
    rst_i = 0;
  endtask

  task automatic test_dm_formats();
    vecs[0] = '{1'b0, 32'h0000_1003, 2'd0, 1'b1, 32'h0, 32'h80FF_FF12, 4'hF, 32'h0, 32'hFFFF_FF80};
    vecs[1] = '{1'b0, 32'h0000_1002, 2'd1, 1'b0, 32'h0, 32'h8234_0000, 4'hF, 32'h0, 32'h0000_8234};
    vecs[2] = '{1'b0, 32'h0000_1002, 2'd1, 1'b1, 32'h0, 32'h8234_0000, 4'hF, 32'h0, 32'hFFFF_8234};
    vecs[3] = '{1'b0, 32'h0000_1001, 2'd0, 1'b0, 32'h0, 32'h0000_9A00, 4'hF, 32'h0, 32'h0000_009A};
    vecs[4] = '{1'b0, 32'h0000_1000, 2'd2, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_ABCD, 32'h1234_5678, 4'hC, 32'hABCD_ABCD, 32'h0};
    vecs[6] = '{1'b1, 32'h0000_0001, 2'd0, 1'b0, 32'h1234_565A, 32'h1234_5678, 4'h2, 32'h5A5A_5A5A, 32'h0};
    vecs[7] = '{1'b1, 32'h0000_0004, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h1234_5678, 4'hF, 32'hCAFE_F00D, 32'h0};
    vecs[8] = '{1'b0, 32'h0000_1000, 2'd0, 1'b1, 32'h0, 32'h0000_007F, 4'hF, 32'h0, 32'h0000_007F};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      dm_req_i = 1; dm_we_i = vecs[i].we; dm_addr_i = vecs[i].addr; dm_type_i = vecs[i].typ;
      dm_sign_ext_i = vecs[i].sext; dm_wdata_i = vecs[i].wdata;
      mem_ready_i = 0; mem_rvalid_i = 0;
      #1;
      total++;
      if ({dm_gnt_o, if_gnt_o, mem_req_o, dm_misaligned_o} !== 4'b1000) begin
        bad++; $display("FAIL fmt_grant[%0d]: gnt/ifgnt/req/mis=%b want 1000", i, {dm_gnt_o, if_gnt_o, mem_req_o, dm_misaligned_o});
      end
      @(negedge clk_i);
      dm_req_i = 0; mem_ready_i = 1;
      #1;
      total++;
      if (mem_req_o !== 1'b1 || mem_we_o !== vecs[i].we || mem_addr_o !== (vecs[i].addr & 32'hFFFF_FFFC)) begin
        bad++; $display("FAIL fmt_req[%0d]: req=%b we=%b addr=%h want 1 %b %h", i, mem_req_o, mem_we_o, mem_addr_o, vecs[i].we, vecs[i].addr & 32'hFFFF_FFFC);
      end
      total++;
      if (mem_be_o !== vecs[i].be || mem_wdata_o !== vecs[i].exp_wdata) begin
        bad++; $display("FAIL fmt_lanes[%0d]: be=%h wdata=%h want %h %h", i, mem_be_o, mem_wdata_o, vecs[i].be, vecs[i].exp_wdata);
      end
      @(negedge clk_i);
      mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = vecs[i].rdata;
      #1;
      total++;
      if (dm_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0 || dm_rdata_o !== vecs[i].exp_rdata) begin
        bad++; $display("FAIL fmt_resp[%0d]: rvalid=%b if_rvalid=%b rdata=%h want 1 0 %h", i, dm_rvalid_o, if_rvalid_o, dm_rdata_o, vecs[i].exp_rdata);
      end
      @(negedge clk_i);
      mem_rvalid_i = 0; mem_rdata_i = 32'h5555_5555;
      #1;
      total++;
      if (dm_rvalid_o !== 1'b0 || dm_rdata_o !== vecs[i].exp_rdata || mem_req_o !== 1'b0) begin
        bad++; $display("FAIL fmt_hold[%0d]: rvalid=%b rdata=%h req=%b want 0 %h 0", i, dm_rvalid_o, dm_rdata_o, mem_req_o, vecs[i].exp_rdata);
      end
    end
  endtask

  task automatic test_contention();
    logic exp_dm [11];
    int   n;
    exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    n = 0;
    @(negedge clk_i);
    if_req_i = 1; if_addr_i = 32'h0000_0400;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h0000_0100; dm_type_i = 2'd2; dm_sign_ext_i = 0;
    mem_ready_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
    for (int cyc = 0; cyc < 80 && n < 11; cyc++) begin
      #1;
      if (dm_gnt_o === 1'b1 || if_gnt_o === 1'b1) begin
        total++;
        if (dm_gnt_o !== exp_dm[n] || if_gnt_o !== !exp_dm[n]) begin
          bad++; $display("FAIL contention_order[%0d]: dm_gnt=%b if_gnt=%b want dm_gnt=%b", n, dm_gnt_o, if_gnt_o, exp_dm[n]);
        end
        n++;
      end
      @(negedge clk_i);
    end
    total++;
    if (n != 11) begin
      bad++; $display("FAIL contention_timeout: grants=%0d want 11", n);
    end
    if_req_i = 0; dm_req_i = 0;
    repeat (3) @(negedge clk_i);
    mem_ready_i = 0; mem_rvalid_i = 0;
    #1;
    total++;
    if (if_rdata_o !== 32'h0000_0013 || mem_req_o !== 1'b0) begin
      bad++; $display("FAIL contention_if_data: if_rdata=%h req=%b want 00000013 0", if_rdata_o, mem_req_o);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk_i);
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h0000_3000; dm_type_i = 2'd2; dm_wdata_i = 32'h1122_3344;
    mem_ready_i = 0; mem_rvalid_i = 0;
    #1;
    total++;
    if (dm_gnt_o !== 1'b1) begin
      bad++; $display("FAIL bp_grant: got %b want 1", dm_gnt_o);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      dm_req_i = 0; dm_addr_i = 32'hFFFF_FFF0 + k; dm_wdata_i = ~dm_wdata_i;
      mem_ready_i = 0; mem_rvalid_i = 1;
      #1;
      total++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_3000 ||
          mem_be_o !== 4'hF || mem_wdata_o !== 32'h1122_3344 || dm_rvalid_o !== 1'b0) begin
        bad++; $display("FAIL bp_stable[%0d]: req=%b we=%b addr=%h be=%h wdata=%h rvalid=%b want 1 1 00003000 f 11223344 0",
                        k, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, dm_rvalid_o);
      end
    end
    @(negedge clk_i);
    mem_rvalid_i = 0; mem_ready_i = 1;
    #1;
    total++;
    if (mem_req_o !== 1'b1) begin
      bad++; $display("FAIL bp_ready: req=%b want 1", mem_req_o);
    end
    @(negedge clk_i);
    mem_ready_i = 0;
    #1;
    total++;
    if (mem_req_o !== 1'b0 || dm_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL bp_wait_resp: req=%b rvalid=%b want 0 0", mem_req_o, dm_rvalid_o);
    end
    @(negedge clk_i);
    mem_rvalid_i = 1; mem_rdata_i = 32'h9999_9999;
    #1;
    total++;
    if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== 32'h0) begin
      bad++; $display("FAIL bp_store_done: rvalid=%b rdata=%h want 1 00000000", dm_rvalid_o, dm_rdata_o);
    end
    @(negedge clk_i);
    mem_rvalid_i = 0;
  endtask

  task automatic test_misaligned();
    @(negedge clk_i);
    dm_req_i = 1; dm_we_i = 0; dm_type_i = 2'd1; dm_addr_i = 32'h0000_3001; if_req_i = 0;
    #1;
    total++;
    if ({dm_gnt_o, dm_misaligned_o, mem_req_o} !== 3'b110) begin
      bad++; $display("FAIL mis_half: gnt/mis/req=%b want 110", {dm_gnt_o, dm_misaligned_o, mem_req_o});
    end
    @(negedge clk_i);
    dm_type_i = 2'd2; dm_addr_i = 32'h0000_3002; if_req_i = 1; if_addr_i = 32'h0000_0500;
    #1;
    total++;
    if ({dm_gnt_o, dm_misaligned_o, if_gnt_o, mem_req_o} !== 4'b1100) begin
      bad++; $display("FAIL mis_word: gnt/mis/ifgnt/req=%b want 1100", {dm_gnt_o, dm_misaligned_o, if_gnt_o, mem_req_o});
    end
    @(negedge clk_i);
    dm_req_i = 0;
    #1;
    total++;
    if ({if_gnt_o, dm_misaligned_o, mem_req_o} !== 3'b100) begin
      bad++; $display("FAIL mis_if_next: ifgnt/mis/req=%b want 100", {if_gnt_o, dm_misaligned_o, mem_req_o});
    end
    @(negedge clk_i);
    if_req_i = 0; mem_ready_i = 1;
    #1;
    total++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h0000_0500 || mem_be_o !== 4'hF) begin
      bad++; $display("FAIL mis_if_req: req=%b we=%b addr=%h be=%h want 1 0 00000500 f", mem_req_o, mem_we_o, mem_addr_o, mem_be_o);
    end
    @(negedge clk_i);
    mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5_0001;
    #1;
    total++;
    if (if_rvalid_o !== 1'b1 || dm_rvalid_o !== 1'b0 || if_rdata_o !== 32'hA5A5_0001) begin
      bad++; $display("FAIL mis_if_resp: if_rvalid=%b dm_rvalid=%b if_rdata=%h want 1 0 a5a50001", if_rvalid_o, dm_rvalid_o, if_rdata_o);
    end
    @(negedge clk_i);
    mem_rvalid_i = 0;
  endtask

  task automatic test_reset_midop();
    @(negedge clk_i);
    dm_req_i = 1; dm_we_i = 0; dm_type_i = 2'd2; dm_addr_i = 32'h0000_1000;
    #1;
    total++;
    if (dm_gnt_o !== 1'b1) begin
      bad++; $display("FAIL rst_mid_grant: got %b want 1", dm_gnt_o);
    end
    @(negedge clk_i);
    dm_req_i = 0; mem_ready_i = 1;
    #1;
    total++;
    if (mem_req_o !== 1'b1) begin
      bad++; $display("FAIL rst_mid_req: got %b want 1", mem_req_o);
    end
    @(negedge clk_i);
    mem_ready_i = 0;
    #1;
    rst_i = 1;
    #1;
    total++;
    if ({if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, dm_misaligned_o, mem_req_o, mem_we_o} !== 7'b0 ||
        {mem_addr_o, mem_be_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs: req=%b addr=%h be=%h if_rdata=%h dm_rdata=%h want all 0", mem_req_o, mem_addr_o, mem_be_o, if_rdata_o, dm_rdata_o);
    end
    @(negedge clk_i);
    rst_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_BAD0;
    #1;
    total++;
    if ({dm_rvalid_o, if_rvalid_o, mem_req_o} !== 3'b000 || dm_rdata_o !== 32'h0 || if_rdata_o !== 32'h0) begin
      bad++; $display("FAIL rst_stale_resp: dm_rv=%b if_rv=%b req=%b dm_rdata=%h if_rdata=%h want 0 0 0 0 0", dm_rvalid_o, if_rvalid_o, mem_req_o, dm_rdata_o, if_rdata_o);
    end
    @(negedge clk_i);
    mem_rvalid_i = 0; if_req_i = 1; if_addr_i = 32'h0000_0600;
    #1;
    total++;
    if (if_gnt_o !== 1'b1) begin
      bad++; $display("FAIL rst_if_grant: got %b want 1", if_gnt_o);
    end
    @(negedge clk_i);
    if_req_i = 0; mem_ready_i = 1;
    #1;
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0600) begin
      bad++; $display("FAIL rst_if_req: req=%b addr=%h want 1 00000600", mem_req_o, mem_addr_o);
    end
    @(negedge clk_i);
    mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0F0F_0F0F;
    #1;
    total++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h0F0F_0F0F) begin
      bad++; $display("FAIL rst_if_resp: rvalid=%b rdata=%h want 1 0f0f0f0f", if_rvalid_o, if_rdata_o);
    end
    @(negedge clk_i);
    mem_rvalid_i = 0;
  endtask

  initial begin
    test_reset();
    test_dm_formats();
    test_contention();
    test_backpressure();
    test_misaligned();
    test_reset_midop();
    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
